keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Scans a 4x4 active-low key matrix: drives one column low at a time and samples the rows.
- Debounces press and release, then presents a stable 16-bit one-hot key vector, a 4-bit digit code and a one-cycle valid strobe.
- Sits between the keypad pins and the display/digit-entry logic.
- It is the sequencer that produces the one-hot key vector consumed by the keypad encoder stage.

Parameters:
- CLK_DIV, 50000, clk cycles per scan tick (column dwell time); legal range ≥2.
- DEBOUNCE_TICKS, 4, consecutive matching ticks required to accept a press or release; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row_in  in  4  raw matrix rows, active-low (pull-ups), asynchronous to clk
- col_out  out  4  column drive, exactly one bit low while scanning
- onehot  out  16  accepted key; bit index = 4*col + row; all-zero when no key held
- key_code  out  4  digit code of last accepted key
- key_is_digit  out  1  last accepted key maps to a digit
- key_valid  out  1  one-cycle pulse on each accepted press
- key_held  out  1  high while an accepted key remains down

Behaviour:
- Reset (async, immediate) values:
  - col_out=4'hE; onehot=0; key_code=0; key_is_digit=0; key_valid=0; key_held=0.
  - State SCAN; column index 0; tick and debounce counters 0; row synchronizer 4'hF.
- Input sync: row_in passes through a 2-flop synchronizer (rs). All decisions use rs, sampled only on scan_tick.
- scan_tick: 1-cycle pulse every CLK_DIV clk cycles from a free-running counter, 0..CLK_DIV-1; the pulse fires when the counter equals CLK_DIV-1. The counter is never stopped.
- col_out = ~(4'b1 << col), registered. It changes only on scan_tick.
- SCAN:
  - On tick, rs all-high → col advances 3→0 wrap.
  - On tick, exactly one rs bit low → capture (col,row), hold col, cnt=1, go DEBOUNCE.
  - On tick, two or more rs bits low (ghost/multi-press) → ignore and advance col.
- DEBOUNCE:
  - On tick, the same single row is low → cnt+1.
  - When cnt reaches DEBOUNCE_TICKS → go PRESSED. On the same edge, register onehot, key_code, key_is_digit; key_held=1; key_valid=1 for exactly one cycle.
  - On tick, any other rs pattern → cnt=0, outputs unchanged, go SCAN, col advances.
  - DEBOUNCE_TICKS=1 → accept on the detection tick itself.
- PRESSED: col held. On tick, rs all-high → cnt=1, go RELEASE. Any other pattern (including extra keys) → stay; no new valid.
- RELEASE:
  - On tick, rs all-high → cnt+1.
  - When cnt reaches DEBOUNCE_TICKS → onehot=0, key_held=0, go SCAN, col advances.
  - key_code and key_is_digit retain the last accepted key after release.
  - Captured row low again → cnt=0, back to PRESSED, no valid pulse.
- Digit map (onehot bit → key_code):
  - 3→0, 7→1, 6→2, 5→3, 11→4, 10→5, 9→6, 15→7, 14→8, 13→9: key_is_digit=1.
  - All other bits: key_code=4'hF, key_is_digit=0.
- Latency: key_valid rises on the clk edge of the DEBOUNCE_TICKS-th matching tick. For DEBOUNCE_TICKS=N this is (N-1)*CLK_DIV cycles after the detecting tick.
- key_valid never asserts on two consecutive cycles. At most one pulse per press/release cycle.
- Reset asserted mid-press → all outputs return to reset values at once. After release of reset, a still-held key is re-detected as a fresh press.

Decomposition:
- Package keypad_pkg holds:
  - state typedef {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - NUM_ROWS=4, NUM_COLS=4
  - 16-entry digit-map constant (code plus digit flag) used above
- One sub-module: scan_tick_gen (parameter CLK_DIV; ports clk, rst, tick). The FSM, synchronizer and map stay in keypad_scan_ctrl.

Test Plan:
(All scenarios use CLK_DIV=4, DEBOUNCE_TICKS=3.)
1. Idle, rows 4'hF for 64 cycles → col_out cycles E,D,B,7,E every 4 cycles; key_valid never asserted; onehot=0.
2. Hold row1 low while col 1 driven, steady → after 3 ticks onehot=16'h0020 (bit 5), key_code=3, key_is_digit=1, single key_valid; col_out frozen at 4'hD; release 3 ticks → onehot=0, key_held=0, scan resumes at col 2.
3. Press col3/row1 (bit 13) with 1-tick bounce (low, high, low) → no key_valid; clean 3-tick press then → onehot=16'h2000, key_code=9.
4. Press bit 0 (col0/row0) → key_code=4'hF, key_is_digit=0, key_valid pulsed; two rows low in same column → ignored, no valid.
5. Key held, then 1-tick release glitch in RELEASE → returns to PRESSED, onehot unchanged, no second key_valid.
6. Assert rst for 1 cycle mid-PRESSED → outputs immediately at reset values; key still held → new key_valid 2 ticks after the first post-reset detecting tick.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and digit map for the keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    // Entry = {is_digit, code}; indexed by key bit 4*col+row.
    localparam logic [4:0] DIGIT_MAP [16] = '{
        5'h0F, 5'h0F, 5'h0F, 5'h10,
        5'h0F, 5'h13, 5'h12, 5'h11,
        5'h0F, 5'h16, 5'h15, 5'h14,
        5'h0F, 5'h19, 5'h18, 5'h17
    };

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider producing the column dwell tick
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ROWS-1:0]    row_in,
    output logic [NUM_COLS-1:0]    col_out,
    output logic [15:0]            onehot,
    output logic [3:0]             key_code,
    output logic                   key_is_digit,
    output logic                   key_valid,
    output logic                   key_held
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DT_M1 = CW'(DEBOUNCE_TICKS - 1);

    state_t              state;
    logic [1:0]          col;
    logic [1:0]          cap_row;
    logic [CW-1:0]       cnt;
    logic [NUM_ROWS-1:0] rs_meta;
    logic [NUM_ROWS-1:0] rs;
    logic                tick;

    logic [NUM_ROWS-1:0] low;
    logic [1:0]          row_idx;
    logic                all_high;
    logic                single;
    logic                hit;
    logic                accept;
    logic                release_done;
    logic [3:0]          key_idx;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        low     = ~rs;
        row_idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (low[i]) row_idx = 2'(i);
        end
        all_high = (rs == '1);
        single   = $onehot(low);
        hit      = single && ((state == SCAN) || (row_idx == cap_row));
        key_idx  = {col, row_idx};
        // DEBOUNCE_TICKS==1 accepts/releases on the very first matching tick.
        accept       = tick && hit &&
                       (((state == SCAN) && (DEBOUNCE_TICKS == 1)) ||
                        ((state == DEBOUNCE) && (cnt == DT_M1)));
        release_done = tick && all_high &&
                       (((state == PRESSED) && (DEBOUNCE_TICKS == 1)) ||
                        ((state == RELEASE) && (cnt == DT_M1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            col          <= '0;
            cap_row      <= '0;
            cnt          <= '0;
            rs_meta      <= '1;
            rs           <= '1;
            col_out      <= 4'hE;
            onehot       <= '0;
            key_code     <= '0;
            key_is_digit <= 1'b0;
            key_valid    <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            rs_meta   <= row_in;
            rs        <= rs_meta;
            key_valid <= 1'b0;
            if (accept) begin
                state        <= PRESSED;
                cap_row      <= row_idx;
                cnt          <= '0;
                onehot       <= 16'b1 << key_idx;
                key_is_digit <= DIGIT_MAP[key_idx][4];
                key_code     <= DIGIT_MAP[key_idx][3:0];
                key_held     <= 1'b1;
                key_valid    <= 1'b1;
            end else if (release_done) begin
                state    <= SCAN;
                cnt      <= '0;
                onehot   <= '0;
                key_held <= 1'b0;
                col      <= col + 2'd1;
                col_out  <= col_drive(col + 2'd1);
            end else if (tick) begin
                case (state)
                    SCAN: begin
                        if (single) begin
                            cap_row <= row_idx;
                            cnt     <= CW'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= col + 2'd1;
                            col_out <= col_drive(col + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (hit) begin
                            cnt <= cnt + CW'(1);
                        end else begin
                            cnt     <= '0;
                            state   <= SCAN;
                            col     <= col + 2'd1;
                            col_out <= col_drive(col + 2'd1);
                        end
                    end
                    PRESSED: begin
                        if (all_high) begin
                            cnt   <= CW'(1);
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (all_high) begin
                            cnt <= cnt + CW'(1);
                        end else if (!rs[cap_row]) begin
                            cnt   <= '0;
                            state <= PRESSED;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed table-driven bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_is_digit;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          vcount   = 0;
    int          dbl      = 0;
    logic        prev_v   = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .row_in       (row_in),
        .col_out      (col_out),
        .onehot       (onehot),
        .key_code     (key_code),
        .key_is_digit (key_is_digit),
        .key_valid    (key_valid),
        .key_held     (key_held)
    );

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[4*c+r] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    typedef struct {
        int          ncyc;
        logic [15:0] keys;
        logic [3:0]  col;
        logic [15:0] onehot;
        logic [3:0]  code;
        logic        digit;
        logic        held;
        int          nvalid;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (key_valid) begin
                vcount++;
                if (prev_v) dbl++;
            end
            prev_v = key_valid;
        end
    endtask

    initial begin
        int v0;
        vecs[0]  = '{3,  16'h0000, 4'hE, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1,  16'h0000, 4'hD, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[2]  = '{4,  16'h0000, 4'hB, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[3]  = '{4,  16'h0000, 4'h7, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[4]  = '{4,  16'h0000, 4'hE, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[5]  = '{48, 16'h0000, 4'hE, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[6]  = '{8,  16'h0020, 4'hD, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[7]  = '{7,  16'h0020, 4'hD, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[8]  = '{1,  16'h0020, 4'hD, 16'h0020, 4'h3, 1'b1, 1'b1, 1};
        vecs[9]  = '{16, 16'h0020, 4'hD, 16'h0020, 4'h3, 1'b1, 1'b1, 0};
        vecs[10] = '{11, 16'h0000, 4'hD, 16'h0020, 4'h3, 1'b1, 1'b1, 0};
        vecs[11] = '{1,  16'h0000, 4'hB, 16'h0000, 4'h3, 1'b1, 1'b0, 0};
        vecs[12] = '{8,  16'h2000, 4'h7, 16'h0000, 4'h3, 1'b1, 1'b0, 0};
        vecs[13] = '{4,  16'h0000, 4'hE, 16'h0000, 4'h3, 1'b1, 1'b0, 0};
        vecs[14] = '{23, 16'h2000, 4'h7, 16'h0000, 4'h3, 1'b1, 1'b0, 0};
        vecs[15] = '{1,  16'h2000, 4'h7, 16'h2000, 4'h9, 1'b1, 1'b1, 1};
        vecs[16] = '{12, 16'h0000, 4'hE, 16'h0000, 4'h9, 1'b1, 1'b0, 0};
        vecs[17] = '{12, 16'h0001, 4'hE, 16'h0001, 4'hF, 1'b0, 1'b1, 1};
        vecs[18] = '{12, 16'h0000, 4'hD, 16'h0000, 4'hF, 1'b0, 1'b0, 0};
        vecs[19] = '{20, 16'h0050, 4'hB, 16'h0000, 4'hF, 1'b0, 1'b0, 0};
        vecs[20] = '{12, 16'h0400, 4'hB, 16'h0400, 4'h5, 1'b1, 1'b1, 1};
        vecs[21] = '{4,  16'h0000, 4'hB, 16'h0400, 4'h5, 1'b1, 1'b1, 0};
        vecs[22] = '{12, 16'h0400, 4'hB, 16'h0400, 4'h5, 1'b1, 1'b1, 0};
        vecs[23] = '{8,  16'h0000, 4'hB, 16'h0400, 4'h5, 1'b1, 1'b1, 0};
        vecs[24] = '{4,  16'h0000, 4'h7, 16'h0000, 4'h5, 1'b1, 1'b0, 0};

        rst  = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        check("rst col_out", 32'(col_out), 32'hE);
        check("rst onehot", 32'(onehot), 32'h0);
        check("rst key_code", 32'(key_code), 32'h0);
        check("rst key_is_digit", 32'(key_is_digit), 32'h0);
        check("rst key_valid", 32'(key_valid), 32'h0);
        check("rst key_held", 32'(key_held), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            keys = vecs[i].keys;
            v0   = vcount;
            step(vecs[i].ncyc);
            check($sformatf("v%0d col_out", i), 32'(col_out), 32'(vecs[i].col));
            check($sformatf("v%0d onehot", i), 32'(onehot), 32'(vecs[i].onehot));
            check($sformatf("v%0d key_code", i), 32'(key_code), 32'(vecs[i].code));
            check($sformatf("v%0d key_is_digit", i), 32'(key_is_digit), 32'(vecs[i].digit));
            check($sformatf("v%0d key_held", i), 32'(key_held), 32'(vecs[i].held));
            check($sformatf("v%0d valid_pulses", i), 32'(vcount - v0), 32'(vecs[i].nvalid));
        end

        // Reset in the middle of a held key, then re-detection of the same key.
        keys = 16'h8000;
        v0   = vcount;
        step(12);
        check("pre_rst onehot", 32'(onehot), 32'h8000);
        check("pre_rst key_code", 32'(key_code), 32'h7);
        check("pre_rst valid_pulses", 32'(vcount - v0), 32'd1);
        step(8);
        rst = 1'b1;
        #1;
        check("async_rst col_out", 32'(col_out), 32'hE);
        check("async_rst onehot", 32'(onehot), 32'h0);
        check("async_rst key_code", 32'(key_code), 32'h0);
        check("async_rst key_is_digit", 32'(key_is_digit), 32'h0);
        check("async_rst key_held", 32'(key_held), 32'h0);
        check("async_rst key_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        prev_v = 1'b0;
        v0     = vcount;
        step(23);
        check("post_rst early onehot", 32'(onehot), 32'h0);
        check("post_rst early col_out", 32'(col_out), 32'h7);
        check("post_rst early valid_pulses", 32'(vcount - v0), 32'd0);
        step(1);
        check("post_rst onehot", 32'(onehot), 32'h8000);
        check("post_rst key_code", 32'(key_code), 32'h7);
        check("post_rst key_is_digit", 32'(key_is_digit), 32'h1);
        check("post_rst key_held", 32'(key_held), 32'h1);
        check("post_rst valid_pulses", 32'(vcount - v0), 32'd1);
        step(8);
        check("post_rst no_repeat", 32'(vcount - v0), 32'd1);

        check("back_to_back valid", 32'(dbl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
